regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 two-read/one-write register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback.
- Uses round-robin arbitration and a valid/ready handshake.
- Suppresses writes to register 0.
- Optionally runs a post-reset sequence that clears every register.
- Sits directly in front of the regfile write port and drives RegWrite, WriteRegister and WriteData.

---
 rtl/regfile_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback.
// Define REGFILE_INIT_CLEAR_EN to clear registers 1..NUM_REGS-1 after reset.
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req0Valid,
  input  logic [ADDR_WIDTH-1:0] Req0Addr,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic [ADDR_WIDTH-1:0] Req1Addr,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  output logic                  Req1Ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  InitDone,
  output logic                  LastGrant
);

  if (NUM_REGS > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("NUM_REGS exceeds the register address space");
  end

  logic                  arb;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  gnt0;
  logic                  gnt1;

  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_q, last_d;

`ifdef REGFILE_INIT_CLEAR_EN
  localparam int CW = $clog2(NUM_REGS) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(NUM_REGS);

  typedef enum logic {S_INIT, S_ARB} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= CW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs 1..NUM_REGS-1 issuing writes, then one idle step into ARB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == CNT_END) begin
        state_d = S_ARB;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    arb       = (state_q == S_ARB);
    init_wr   = (state_q == S_INIT) && (cnt_q != CNT_END);
    init_addr = ADDR_WIDTH'(cnt_q);
  end

  assign InitDone = arb;
`else
  assign arb       = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign InitDone  = 1'b1;
`endif

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb && !Reset) begin
      if (Req0Valid && Req1Valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = Req0Valid;
        gnt1 = Req1Valid;
      end
    end
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;

  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    if (init_wr) begin
      regwrite_d = 1'b1;
      wreg_d     = init_addr;
      wdata_d    = '0;
    end else if (gnt0) begin
      regwrite_d = |Req0Addr;
      wreg_d     = Req0Addr;
      wdata_d    = Req0Data;
      last_d     = 1'b0;
    end else if (gnt1) begin
      regwrite_d = |Req1Addr;
      wreg_d     = Req1Addr;
      wdata_d    = Req1Data;
      last_d     = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b1;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign LastGrant     = last_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a behavioural regfile model.
// Works with or without REGFILE_INIT_CLEAR_EN defined.
module tb_regfile_write_arbiter;

  localparam int NR = 32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        r0, r1;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        InitDone;
  logic        LastGrant;

  regfile_write_arbiter #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .NUM_REGS  (NR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req0Valid    (v0),
    .Req0Addr     (a0),
    .Req0Data     (d0),
    .Req0Ready    (r0),
    .Req1Valid    (v1),
    .Req1Addr     (a1),
    .Req1Data     (d1),
    .Req1Ready    (r1),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .InitDone     (InitDone),
    .LastGrant    (LastGrant)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        lg;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem_ref[NR];
  logic [31:0] mem_dut[NR];

  // Reference model state
  int          init_k;
  int          m_last;
  logic [4:0]  m_a;
  logic [31:0] m_d;
  int          m_win;

`ifdef REGFILE_INIT_CLEAR_EN
  localparam int INIT_START = 1;
  localparam logic [31:0] MEM_INIT = 32'hDEADBEEF;
`else
  localparam int INIT_START = NR + 1;
  localparam logic [31:0] MEM_INIT = 32'h0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Regfile fed by the DUT write port
  always @(posedge Clk) begin
    if (RegWrite === 1'b1) mem_dut[WriteRegister] <= WriteData;
  end

  // Monitor: each cycle the DUT presents a registered write-port state
  always begin : mon
    exp_t e;
    @(posedge Clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("RegWrite", 32'(RegWrite), 32'(e.we));
      chk("WriteRegister", 32'(WriteRegister), 32'(e.a));
      chk("WriteData", WriteData, e.d);
      chk("LastGrant", 32'(LastGrant), 32'(e.lg));
    end
  end

  function automatic bit m_arb();
    return init_k > NR;
  endfunction

  // One cycle: drive inputs at negedge, predict, check Ready, push expectation.
  task automatic step(input bit rst,
                      input bit iv0, input logic [4:0] ia0, input logic [31:0] id0,
                      input bit iv1, input logic [4:0] ia1, input logic [31:0] id1);
    exp_t e;
    Reset = rst;
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    #1;
    m_win = -1;
    if (rst) begin
      chk("Req0Ready_rst", 32'(r0), 32'd0);
      chk("Req1Ready_rst", 32'(r1), 32'd0);
      m_last = 1;
      m_a = '0;
      m_d = '0;
      init_k = INIT_START;
      e = '{we: 1'b0, a: 5'd0, d: 32'd0, lg: 1'b1};
    end else begin
      chk("InitDone", 32'(InitDone), 32'(m_arb()));
      if (m_arb()) begin
        if (iv0 && iv1) m_win = 1 - m_last;
        else if (iv0) m_win = 0;
        else if (iv1) m_win = 1;
      end
      chk("Req0Ready", 32'(r0), 32'(m_win == 0));
      chk("Req1Ready", 32'(r1), 32'(m_win == 1));
      if (!m_arb()) begin
        if (init_k < NR) begin
          m_a = 5'(init_k);
          m_d = '0;
          mem_ref[init_k] = '0;
          e = '{we: 1'b1, a: m_a, d: m_d, lg: 1'(m_last)};
        end else begin
          e = '{we: 1'b0, a: m_a, d: m_d, lg: 1'(m_last)};
        end
        init_k++;
      end else if (m_win >= 0) begin
        m_a = (m_win == 0) ? ia0 : ia1;
        m_d = (m_win == 0) ? id0 : id1;
        m_last = m_win;
        if (m_a != 0) mem_ref[m_a] = m_d;
        e = '{we: (m_a != 0), a: m_a, d: m_d, lg: 1'(m_last)};
      end else begin
        e = '{we: 1'b0, a: m_a, d: m_d, lg: 1'(m_last)};
      end
    end
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic wait_init();
    for (int k = 0; k < 40 && !m_arb(); k++) idle();
    chk("init_bound", 32'(m_arb()), 32'd1);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic rand_run(input int n);
    bit          p0, p1;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    p0 = 0; p1 = 0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < n; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; ra0 = 5'($urandom_range(0, NR - 1)); rd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; ra1 = 5'($urandom_range(0, NR - 1)); rd1 = $urandom;
      end
      step(0, p0, ra0, rd0, p1, ra1, rd1);
      if (m_win == 0) p0 = 0;
      if (m_win == 1) p1 = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      mem_ref[i] = MEM_INIT;
      mem_dut[i] = MEM_INIT;
    end
    Reset = 1'b1;
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    init_k = INIT_START;
    m_last = 1; m_a = '0; m_d = '0; m_win = -1;
    @(negedge Clk);
    do_reset();
    wait_init();

    // Single requester
    step(0, 1, 5'd5, 32'd42, 0, 5'd0, 32'd0);
    idle();
    // Tie: both valid every cycle
    for (int i = 0; i < 4; i++) step(0, 1, 5'd2, 32'd15, 1, 5'd3, 32'd30);
    // Register 0 filter
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd15);
    // Same-address collision with LastGrant=1
    step(0, 1, 5'd7, 32'd11, 1, 5'd7, 32'd22);
    step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'd22);
    idle();
    idle();
    chk("reg2", mem_dut[2], 32'd15);
    chk("reg3", mem_dut[3], 32'd30);
    chk("reg5", mem_dut[5], 32'd42);
    chk("reg7", mem_dut[7], 32'd22);
    chk("reg0", mem_dut[0], MEM_INIT);

    rand_run(300);

    // Reset during ARB with both valid
    step(1, 1, 5'd9, 32'd1, 1, 5'd10, 32'd2);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    // Reset again after ten cycles (mid-clear when enabled)
    for (int i = 0; i < 8; i++) idle();
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    wait_init();

    rand_run(200);
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'd0);
    for (int i = 0; i < NR; i++) chk($sformatf("mem%0d", i), mem_dut[i], mem_ref[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
